// File: rtl/timer_bank.sv
// timer_bank: NCH independent millisecond timers sharing one command port.
// Each channel counts clock cycles in a sub-counter (one ms per wrap) and
// milliseconds in a down-counter, so no Tms*CLK_HZ product is ever formed.
// Command port: wr_en is a single-cycle strobe with no ready; a command is
// accepted on every edge where wr_en is high and wr_ch addresses an existing
// channel. The per-channel FSM state is observable on busy (1 = RUN).
module timer_bank #(
    parameter int CLK_HZ = 50000000,
    parameter int NCH    = 4,
    parameter int TW     = 13
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                wr_en,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] wr_ch,
    input  logic [TW-1:0]                       wr_tms,
    input  logic                                wr_mode,
    input  logic [NCH-1:0]                      ack,
    output logic [NCH-1:0]                      rdy,
    output logic [NCH-1:0]                      ovf,
    output logic [NCH-1:0]                      busy,
    output logic                                irq
);

    localparam int CPM = CLK_HZ / 1000;                       // cycles per ms
    localparam int SW  = (CPM > 1) ? $clog2(CPM) : 1;
    localparam logic [SW-1:0] SUB_LAST = SW'(CPM - 1);
    localparam logic [SW-1:0] SUB_ONE  = SW'(1);
    localparam logic [TW-1:0] MS_ONE   = TW'(1);

    // Reject parameter sets the counters cannot represent.
    generate
        if ((CLK_HZ % 1000) != 0 || CLK_HZ < 2000) begin : g_bad_clk
            $error("timer_bank: CLK_HZ must be a multiple of 1000 and >= 2000");
        end
        if (NCH < 1 || NCH > 16) begin : g_bad_nch
            $error("timer_bank: NCH must be in 1..16");
        end
    endgenerate

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t          state_q  [NCH];
    state_t          state_d  [NCH];
    logic            mode_q   [NCH];
    logic            mode_d   [NCH];
    logic [TW-1:0]   reload_q [NCH];
    logic [TW-1:0]   reload_d [NCH];
    logic [TW-1:0]   ms_q     [NCH];
    logic [TW-1:0]   ms_d     [NCH];
    logic [SW-1:0]   sub_q    [NCH];
    logic [SW-1:0]   sub_d    [NCH];
    logic [NCH-1:0]  rdy_q, rdy_d;
    logic [NCH-1:0]  ovf_q, ovf_d;
    logic [NCH-1:0]  cmd_sel;
    logic [NCH-1:0]  expire;
    logic            irq_q;

    // Command decode and expiry detection; a wr_ch beyond NCH-1 matches no
    // channel, so such a command falls through and is ignored.
    always_comb begin
        cmd_sel = '0;
        expire  = '0;
        for (int i = 0; i < NCH; i++) begin
            cmd_sel[i] = wr_en && (int'(wr_ch) == i);
            expire[i]  = (state_q[i] == RUN) && (sub_q[i] == SUB_LAST) &&
                         (ms_q[i] == MS_ONE);
        end
    end

    // Next-state logic per channel. A command overrides everything (expiry
    // and ack included); otherwise an expiry sets rdy and beats an ack.
    always_comb begin
        rdy_d = rdy_q;
        ovf_d = ovf_q;
        for (int i = 0; i < NCH; i++) begin
            state_d[i]  = state_q[i];
            mode_d[i]   = mode_q[i];
            reload_d[i] = reload_q[i];
            ms_d[i]     = ms_q[i];
            sub_d[i]    = sub_q[i];

            if (cmd_sel[i]) begin
                rdy_d[i] = 1'b0;
                ovf_d[i] = 1'b0;
                sub_d[i] = '0;
                if (wr_tms != '0) begin
                    state_d[i]  = RUN;
                    mode_d[i]   = wr_mode;
                    reload_d[i] = wr_tms;
                    ms_d[i]     = wr_tms;
                end else begin
                    state_d[i] = IDLE;
                    ms_d[i]    = '0;
                end
            end else begin
                if (state_q[i] == RUN) begin
                    if (sub_q[i] == SUB_LAST) begin
                        sub_d[i] = '0;
                        if (ms_q[i] == MS_ONE) begin
                            // Periodic reload happens on the same wrap, so the
                            // period stays exactly Tms*CPM cycles.
                            if (mode_q[i]) begin
                                ms_d[i] = reload_q[i];
                            end else begin
                                ms_d[i]    = '0;
                                state_d[i] = IDLE;
                            end
                        end else begin
                            ms_d[i] = ms_q[i] - MS_ONE;
                        end
                    end else begin
                        sub_d[i] = sub_q[i] + SUB_ONE;
                    end
                end

                if (expire[i]) begin
                    rdy_d[i] = 1'b1;
                    if (rdy_q[i] && !ack[i]) begin
                        ovf_d[i] = 1'b1;
                    end
                end else if (ack[i]) begin
                    rdy_d[i] = 1'b0;
                    ovf_d[i] = 1'b0;
                end
            end
        end
    end

    // State and datapath registers; reset dominates commands and acks.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i]  <= IDLE;
                mode_q[i]   <= 1'b0;
                reload_q[i] <= '0;
                ms_q[i]     <= '0;
                sub_q[i]    <= '0;
            end
            rdy_q <= '0;
            ovf_q <= '0;
            irq_q <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i]  <= state_d[i];
                mode_q[i]   <= mode_d[i];
                reload_q[i] <= reload_d[i];
                ms_q[i]     <= ms_d[i];
                sub_q[i]    <= sub_d[i];
            end
            rdy_q <= rdy_d;
            ovf_q <= ovf_d;
            irq_q <= |rdy_q;
        end
    end

    // busy mirrors the per-channel FSM state.
    always_comb begin
        busy = '0;
        for (int i = 0; i < NCH; i++) begin
            busy[i] = (state_q[i] == RUN);
        end
    end

    assign rdy = rdy_q;
    assign ovf = ovf_q;
    assign irq = irq_q;

endmodule
